// File: rtl/register_writeback.sv
// register_writeback: write-back stage register, 32 x XLEN register file with
// two combinational read ports, and a busy scoreboard for in-flight writes.
// Optional feature macro: WB_BYPASS_EN (forward the staged result to the
// read ports so it is readable the cycle after its handshake).
module register_writeback #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [4:0]      wb_rd,
  input  logic            wb_RegWrite,
  input  logic            wb_MemtoReg,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_mem_data,
  input  logic            iss_valid,
  input  logic            iss_RegWrite,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            s_valid_q, s_valid_d;
  logic [4:0]      s_rd_q, s_rd_d;
  logic [XLEN-1:0] s_data_q, s_data_d;

  logic accept;
  logic load;
  logic commit;

  // Handshake: a debug write steals the register-file write port, so a
  // pending stage entry cannot drain and the stage cannot accept.
  always_comb begin
    wb_ready = !s_valid_q || !dbg_we;
    accept   = wb_valid && wb_ready;
    load     = accept && wb_RegWrite && (wb_rd != 5'd0);
    commit   = s_valid_q && !dbg_we;
  end

  // Next-state for register array, stage register and scoreboard.
  // Scoreboard set is applied after the commit clear so a same-edge issue wins.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    s_valid_d = s_valid_q;
    s_rd_d    = s_rd_q;
    s_data_d  = s_data_q;

    if (dbg_we) begin
      if (dbg_addr != 5'd0) begin
        regs_d[dbg_addr] = dbg_data;
      end
    end else if (s_valid_q) begin
      regs_d[s_rd_q] = s_data_q;
      busy_d[s_rd_q] = 1'b0;
      s_valid_d      = 1'b0;
    end

    if (load) begin
      s_valid_d = 1'b1;
      s_rd_d    = wb_rd;
      s_data_d  = wb_MemtoReg ? wb_mem_data : wb_alu_result;
    end

    if (iss_valid && iss_RegWrite && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // State registers; reset discards any in-flight stage entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      s_valid_q <= 1'b0;
      s_rd_q    <= '0;
      s_data_q  <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      s_valid_q <= s_valid_d;
      s_rd_q    <= s_rd_d;
      s_data_q  <= s_data_d;
    end
  end

  // Read port 1: x0 reads zero and is never busy.
  always_comb begin
    rd1      = '0;
    rs1_busy = 1'b0;
    if (rs1 != 5'd0) begin
      rd1      = regs_q[rs1];
      rs1_busy = busy_q[rs1];
`ifdef WB_BYPASS_EN
      if (s_valid_q && (s_rd_q == rs1)) begin
        rd1      = s_data_q;
        rs1_busy = 1'b0;
      end
`endif
    end
  end

  // Read port 2: x0 reads zero and is never busy.
  always_comb begin
    rd2      = '0;
    rs2_busy = 1'b0;
    if (rs2 != 5'd0) begin
      rd2      = regs_q[rs2];
      rs2_busy = busy_q[rs2];
`ifdef WB_BYPASS_EN
      if (s_valid_q && (s_rd_q == rs2)) begin
        rd2      = s_data_q;
        rs2_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_writeback.sv
// Self-checking bench for register_writeback: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// register file, the one-deep pending write and the busy bits.
module tb_register_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic        wb_MemtoReg;
  logic [63:0] wb_alu_result;
  logic [63:0] wb_mem_data;
  logic        iss_valid;
  logic        iss_RegWrite;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_r [32];
  logic [31:0] m_busy;
  logic        m_pv;
  logic [4:0]  m_prd;
  logic [63:0] m_pdata;
  logic        last_stall;

  register_writeback #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .iss_valid(iss_valid), .iss_RegWrite(iss_RegWrite), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] rs);
    if (rs == 5'd0) return 64'd0;
`ifdef WB_BYPASS_EN
    if (m_pv && m_prd == rs) return m_pdata;
`endif
    return m_r[rs];
  endfunction

  function automatic logic exp_busy(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (m_pv && m_prd == rs) return 1'b0;
`endif
    return m_busy[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_r[i] = 64'd0;
    m_busy     = '0;
    m_pv       = 1'b0;
    m_prd      = 5'd0;
    m_pdata    = 64'd0;
    last_stall = 1'b0;
  endtask

  // Apply one clock edge of the architectural rules to the model.
  task automatic model_edge();
    logic rdy;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = !m_pv || !dbg_we;
      if (dbg_we) begin
        if (dbg_addr != 5'd0) m_r[dbg_addr] = dbg_data;
      end else if (m_pv) begin
        m_r[m_prd]    = m_pdata;
        m_busy[m_prd] = 1'b0;
        m_pv          = 1'b0;
      end
      if (wb_valid && rdy && wb_RegWrite && wb_rd != 5'd0) begin
        m_pv    = 1'b1;
        m_prd   = wb_rd;
        m_pdata = wb_MemtoReg ? wb_mem_data : wb_alu_result;
      end
      if (iss_valid && iss_RegWrite && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      last_stall = wb_valid && !rdy;
    end
  endtask

  task automatic check_outputs();
    check("wb_ready", {63'd0, wb_ready}, {63'd0, (!m_pv || !dbg_we)});
    check("rd1", rd1, exp_rd(rs1));
    check("rd2", rd2, exp_rd(rs2));
    check("rs1_busy", {63'd0, rs1_busy}, {63'd0, exp_busy(rs1)});
    check("rs2_busy", {63'd0, rs2_busy}, {63'd0, exp_busy(rs2)});
  endtask

  // Inputs are set just after a falling edge; check, take the rising edge,
  // update the model, and return at the next falling edge.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid      = 1'b0;
    wb_rd         = 5'd0;
    wb_RegWrite   = 1'b0;
    wb_MemtoReg   = 1'b0;
    wb_alu_result = 64'd0;
    wb_mem_data   = 64'd0;
    iss_valid     = 1'b0;
    iss_RegWrite  = 1'b0;
    iss_rd        = 5'd0;
    dbg_we        = 1'b0;
    dbg_addr      = 5'd0;
    dbg_data      = 64'd0;
  endtask

  task automatic send_wb(input logic [4:0] rd, input logic wr, input logic m2r,
                         input logic [63:0] alu, input logic [63:0] mem);
    wb_valid = 1'b1; wb_rd = rd; wb_RegWrite = wr; wb_MemtoReg = m2r;
    wb_alu_result = alu; wb_mem_data = mem;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_RegWrite = 1'b1; iss_rd = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rs1 = 5'd0;
    rs2 = 5'd0;
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();

    // Basic write through ALU path, with prior issue marking x5 busy
    issue(5'd5);
    rs1 = 5'd5;
    step();
    idle();
    #1 check("basic_busy_before", {63'd0, rs1_busy}, 64'd1);
    send_wb(5'd5, 1'b1, 1'b0, 64'h1234, 64'h5555);
    step();
    idle();
`ifdef WB_BYPASS_EN
    #1 check("basic_bypass_rd", rd1, 64'h1234);
    check("basic_bypass_busy", {63'd0, rs1_busy}, 64'd0);
`else
    #1 check("basic_early_rd", rd1, 64'd0);
    check("basic_early_busy", {63'd0, rs1_busy}, 64'd1);
`endif
    step();
    #1 check("basic_rd", rd1, 64'h1234);
    check("basic_busy_after", {63'd0, rs1_busy}, 64'd0);

    // MemtoReg selects load data
    send_wb(5'd7, 1'b1, 1'b1, 64'hAA, 64'hDEADBEEF);
    step();
    idle();
    step();
    rs2 = 5'd7;
    #1 check("mux_mem", rd2, 64'hDEADBEEF);

    // x0 and RegWrite=0 requests are consumed without effect
    dbg_we = 1'b1; dbg_addr = 5'd3; dbg_data = 64'h333;
    step();
    idle();
    send_wb(5'd0, 1'b1, 1'b0, 64'hFF, 64'd0);
    #1 check("x0_ready", {63'd0, wb_ready}, 64'd1);
    step();
    send_wb(5'd3, 1'b0, 1'b0, 64'h999, 64'd0);
    #1 check("nowr_ready", {63'd0, wb_ready}, 64'd1);
    step();
    idle();
    step();
    rs1 = 5'd0;
    rs2 = 5'd3;
    #1 check("x0_reads_zero", rd1, 64'd0);
    check("nowr_unchanged", rd2, 64'h333);

    // Debug write collides with a pending stage entry
    send_wb(5'd4, 1'b1, 1'b0, 64'h11, 64'd0);
    issue(5'd4);
    step();
    idle();
    send_wb(5'd6, 1'b1, 1'b0, 64'h66, 64'd0);
    dbg_we = 1'b1; dbg_addr = 5'd4; dbg_data = 64'h22;
    rs1 = 5'd4;
    #1 check("dbg_ready_low", {63'd0, wb_ready}, 64'd0);
    step();
    dbg_we = 1'b0;
`ifdef WB_BYPASS_EN
    #1 check("dbg_mid_rd", rd1, 64'h11);
`else
    #1 check("dbg_mid_rd", rd1, 64'h22);
    check("dbg_mid_busy", {63'd0, rs1_busy}, 64'd1);
`endif
    step();
    idle();
    #1 check("dbg_final_rd", rd1, 64'h11);
    check("dbg_final_busy", {63'd0, rs1_busy}, 64'd0);
    step();

    // Same-edge commit clear and issue set on x9
    send_wb(5'd9, 1'b1, 1'b0, 64'h99, 64'd0);
    step();
    idle();
    issue(5'd9);
    step();
    idle();
    rs1 = 5'd9;
    #1 check("race_busy", {63'd0, rs1_busy}, 64'd1);
    check("race_rd", rd1, 64'h99);
    step();

    // Randomized traffic; requests stalled by a debug write are held
    for (int c = 0; c < 600; c++) begin
      if (!last_stall) begin
        wb_valid      = ($urandom_range(0, 9) < 6);
        wb_rd         = 5'($urandom_range(0, 15));
        wb_RegWrite   = ($urandom_range(0, 9) != 0);
        wb_MemtoReg   = 1'($urandom_range(0, 1));
        wb_alu_result = {$urandom, $urandom};
        wb_mem_data   = {$urandom, $urandom};
      end
      dbg_we       = ($urandom_range(0, 6) == 0);
      dbg_addr     = 5'($urandom_range(0, 15));
      dbg_data     = {$urandom, $urandom};
      iss_valid    = ($urandom_range(0, 2) == 0);
      iss_RegWrite = ($urandom_range(0, 4) != 0);
      iss_rd       = 5'($urandom_range(0, 15));
      rs1          = 5'($urandom_range(0, 15));
      rs2          = 5'($urandom_range(0, 15));
      step();
    end

    // Asynchronous reset with a stage entry in flight
    idle();
    send_wb(5'd10, 1'b1, 1'b0, 64'hABC, 64'd0);
    issue(5'd11);
    step();
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a);
      rs2 = 5'(31 - a);
      #1;
      check("rst_rd1", rd1, 64'd0);
      check("rst_rd2", rd2, 64'd0);
      check("rst_busy1", {63'd0, rs1_busy}, 64'd0);
      check("rst_busy2", {63'd0, rs2_busy}, 64'd0);
      check("rst_ready", {63'd0, wb_ready}, 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rs1 = 5'd10;
    rs2 = 5'd11;
    step();
    step();
    #1 check("rst_no_ghost", rd1, 64'd0);
    check("rst_busy_cleared", {63'd0, rs2_busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
